seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the multi-digit 7-segment display on the BCD adder board. It holds a frame of BCD digits and steps through them one slot at a time. For each slot it presents one digit to the single shared BCD-to-segment decoder and enables that digit's common anode (active-low). A blanking interval between slots suppresses ghosting. New display values take effect only at frame boundaries, so digits never tear mid-frame.

---
 rtl/seg_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit
// common-anode 7-segment display fed by one shared BCD decoder.
// Each digit slot starts with a short blanking interval to suppress ghosting.
// New frames are staged and then committed only at the frame boundary.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (k >= 1) keep their anode off
//   undefined -> every digit is shown, including leading zeros
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic                    load_i,
  output logic                    pending_o,
  output logic [3:0]              dec_in_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o,
  output logic                    bcd_err_o
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_display;
  logic [DW-1:0]         r_staging;
  logic                  r_pending;
  logic [3:0]            r_dec_in;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame;
  logic                  r_bcd_err;

  state_t                w_state_next;
  logic                  w_cnt_wrap;
  logic                  w_frame_now;
  logic [CW-1:0]         w_cnt_next;
  logic [IW-1:0]         w_idx_next;
  logic [DW-1:0]         w_display_next;
  logic [3:0]            w_digit_next;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic                  w_frame_next;

  // True when digit idx is a leading zero that should stay dark.
  function automatic logic digit_suppressed(input logic [DW-1:0] disp,
                                            input logic [IW-1:0] idx);
`ifdef LEADING_ZERO_BLANK_EN
    logic [DW-1:0] upper;
    upper = disp >> (4 * int'(idx));
    return (idx != '0) && (upper == '0);
`else
    return 1'b0 & (|disp) & (|idx);
`endif
  endfunction

  // Next-state logic: slot counter, digit index, frame commit, FSM and outputs.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_cnt_wrap     = (r_cnt == CNT_LAST);
    w_frame_now    = w_cnt_wrap && (r_idx == IDX_LAST);
    w_cnt_next     = w_cnt_wrap ? '0 : r_cnt + 1'b1;
    w_idx_next     = r_idx;
    w_display_next = r_display;
    w_state_next   = r_state;
    w_an_next      = '1;

    if (w_cnt_wrap) begin
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end

    // A same-cycle load at the boundary bypasses the staging register.
    if (w_frame_now) begin
      if (load_i) begin
        w_display_next = data_i;
      end else if (r_pending) begin
        w_display_next = r_staging;
      end
    end

    case (r_state)
      ST_BLANK: if (w_cnt_next == BLANK_LIM) w_state_next = ST_ON;
      ST_ON:    if (w_cnt_wrap)              w_state_next = ST_BLANK;
      default:                               w_state_next = ST_BLANK;
    endcase

    if (w_state_next == ST_ON && !digit_suppressed(w_display_next, w_idx_next)) begin
      w_an_next[w_idx_next] = 1'b0;
    end

    w_digit_next = w_display_next[4*int'(w_idx_next) +: 4];
    // Registered copy of the frame condition lands in the cycle it describes.
    w_frame_next = (w_cnt_next == CNT_LAST) && (w_idx_next == IDX_LAST);
  end

  // State and registered outputs, all evaluated one edge ahead of use.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_BLANK;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_display <= '0;
      r_staging <= '0;
      r_pending <= 1'b0;
      r_dec_in  <= '0;
      r_an      <= '1;
      r_frame   <= 1'b0;
      r_bcd_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_display <= w_display_next;
      r_an      <= w_an_next;
      r_frame   <= w_frame_next;

      if (load_i) begin
        r_staging <= data_i;
      end

      if (w_frame_now) begin
        r_pending <= 1'b0;
      end else if (load_i) begin
        r_pending <= 1'b1;
      end

      // Digit is presented at the start of the slot and held through it.
      if (w_cnt_next == '0) begin
        r_dec_in  <= w_digit_next;
        r_bcd_err <= (w_digit_next > 4'd9);
      end
    end
  end

  assign pending_o = r_pending;
  assign dec_in_o  = r_dec_in;
  assign an_o      = r_an;
  assign frame_o   = r_frame;
  assign bcd_err_o = r_bcd_err;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2).
// Expectations follow LEADING_ZERO_BLANK_EN the same way the design build does.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int CD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        pending_o;
  logic [3:0]  dec_in_o;
  logic [3:0]  an_o;
  logic        frame_o;
  logic        bcd_err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // One scan-frame vector: slot k expectations sit in nibble/bit k.
  typedef struct {
    logic [15:0] data;
    logic [15:0] dec_exp;
    logic [15:0] an_exp;
    logic [3:0]  err_exp;
  } vec_t;

  vec_t vecs[7];

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (CD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_i   (data_i),
    .load_i   (load_i),
    .pending_o(pending_o),
    .dec_in_o (dec_in_o),
    .an_o     (an_o),
    .frame_o  (frame_o),
    .bcd_err_o(bcd_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to the given position inside the frame (at most one frame).
  task automatic goto_pos(input int pos);
    int n;
    n = 0;
    while ((cyc % FRAME) != pos && n < 2 * FRAME) begin
      tick();
      n++;
    end
  endtask

  task automatic load_at(input int pos, input logic [15:0] d);
    goto_pos(pos);
    data_i = d;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  // Expected anode pattern for a slot/count with a given display value.
  function automatic logic [3:0] exp_an(input logic [15:0] disp, input int slot, input int c);
    logic [3:0] a;
    a = 4'b1111;
    if (c >= BC) a[slot] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot != 0) begin
      logic all_zero;
      all_zero = 1'b1;
      for (int k = slot; k < ND; k++) if (disp[4*k +: 4] != 4'd0) all_zero = 1'b0;
      if (all_zero) a = 4'b1111;
    end
`endif
    return a;
  endfunction

  initial begin
    logic [15:0] hand;

    vecs[0] = '{16'h1234, 16'h1234, 16'h7BDE, 4'b0000};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[1] = '{16'h00A0, 16'h00A0, 16'hFFDE, 4'b0010};
    vecs[2] = '{16'h0042, 16'h0042, 16'hFFDE, 4'b0000};
    vecs[3] = '{16'h0000, 16'h0000, 16'hFFFE, 4'b0000};
    vecs[5] = '{16'h0100, 16'h0100, 16'hFBDE, 4'b0000};
`else
    vecs[1] = '{16'h00A0, 16'h00A0, 16'h7BDE, 4'b0010};
    vecs[2] = '{16'h0042, 16'h0042, 16'h7BDE, 4'b0000};
    vecs[3] = '{16'h0000, 16'h0000, 16'h7BDE, 4'b0000};
    vecs[5] = '{16'h0100, 16'h0100, 16'h7BDE, 4'b0000};
`endif
    vecs[4] = '{16'h9F09, 16'h9F09, 16'h7BDE, 4'b0100};
    vecs[6] = '{16'h8000, 16'h8000, 16'h7BDE, 4'b0000};

    // Reset held for three edges.
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_an", 32'(an_o), 32'hF);
      check("rst_dec", 32'(dec_in_o), 32'h0);
      check("rst_frame", 32'(frame_o), 32'h0);
      check("rst_pending", 32'(pending_o), 32'h0);
      check("rst_err", 32'(bcd_err_o), 32'h0);
    end
    rst_n = 1'b1;
    cyc = 0;

    // First frame after release: anode timing and single frame pulse.
    while (cyc < FRAME) begin
      check("scan_an", 32'(an_o), 32'(exp_an(16'h0000, cyc / CD, cyc % CD)));
      check("scan_frame", 32'(frame_o), 32'(cyc == FRAME - 1));
      check("scan_dec", 32'(dec_in_o), 32'h0);
      tick();
    end

    // Load mid-frame: pending until the boundary, then committed.
    load_at(5, 16'h1234);
    while ((cyc % FRAME) != 0) begin
      check("load_pending", 32'(pending_o), 32'h1);
      check("load_frame", 32'(frame_o), 32'((cyc % FRAME) == FRAME - 1));
      tick();
    end
    check("load_pending_clr", 32'(pending_o), 32'h0);
    check("load_dec0", 32'(dec_in_o), 32'h4);

    // Table-driven frames: per slot check blank phase and on phase.
    for (int v = 0; v < 7; v++) begin
      load_at(5, vecs[v].data);
      goto_pos(0);
      for (int s = 0; s < ND; s++) begin
        goto_pos(s * CD);
        check("vec_blank_an", 32'(an_o), 32'hF);
        check("vec_dec", 32'(dec_in_o), 32'(vecs[v].dec_exp[4*s +: 4]));
        check("vec_err", 32'(bcd_err_o), 32'(vecs[v].err_exp[s]));
        tick();
        tick();
        check("vec_on_an", 32'(an_o), 32'(vecs[v].an_exp[4*s +: 4]));
        check("vec_on_dec", 32'(dec_in_o), 32'(vecs[v].dec_exp[4*s +: 4]));
        check("vec_on_err", 32'(bcd_err_o), 32'(vecs[v].err_exp[s]));
      end
    end

    // Overwrite before the boundary: last write wins.
    load_at(5, 16'h1111);
    load_at(20, 16'h2222);
    check("ovw_pending", 32'(pending_o), 32'h1);
    goto_pos(0);
    for (int s = 0; s < ND; s++) begin
      goto_pos(s * CD);
      check("ovw_dec", 32'(dec_in_o), 32'h2);
    end

    // Load exactly on the frame cycle bypasses staging.
    goto_pos(FRAME - 1);
    check("byp_frame", 32'(frame_o), 32'h1);
    check("byp_pending_pre", 32'(pending_o), 32'h0);
    data_i = 16'h5678;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    hand = 16'h5678;
    check("byp_pending", 32'(pending_o), 32'h0);
    for (int s = 0; s < ND; s++) begin
      goto_pos(s * CD);
      check("byp_dec", 32'(dec_in_o), 32'(hand[4*s +: 4]));
      check("byp_pending_hold", 32'(pending_o), 32'h0);
    end

    // Mid-frame reset during slot 1 ON with a load pending.
    load_at(5, 16'h9999);
    goto_pos(13);
    check("mrst_pre_an", 32'(an_o), 32'hD);
    check("mrst_pre_pending", 32'(pending_o), 32'h1);
    rst_n = 1'b0;
    tick();
    check("mrst_an", 32'(an_o), 32'hF);
    check("mrst_pending", 32'(pending_o), 32'h0);
    check("mrst_dec", 32'(dec_in_o), 32'h0);
    check("mrst_frame", 32'(frame_o), 32'h0);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < FRAME) begin
      check("mrst_scan_an", 32'(an_o), 32'(exp_an(16'h0000, cyc / CD, cyc % CD)));
      check("mrst_scan_dec", 32'(dec_in_o), 32'h0);
      check("mrst_scan_frame", 32'(frame_o), 32'(cyc == FRAME - 1));
      tick();
    end
    check("mrst_after_pending", 32'(pending_o), 32'h0);
    check("mrst_after_dec", 32'(dec_in_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
